// File: rtl/stream_fifo_32b.sv
// stream_fifo_32b
//   First-word-fall-through valid/ready FIFO that decouples a PE input mux
//   from its consumer, so the crossbar select can change while words are
//   still in flight.
//
// Ports
//   clk        rising-edge clock
//   rst        synchronous reset, active-high
//   in_data    word offered by the upstream mux
//   in_valid   upstream offers in_data this cycle
//   in_ready   FIFO accepts a word this cycle (never while full or in reset)
//   out_data   head-of-queue word, zero when empty
//   out_valid  out_data holds a valid word
//   out_ready  downstream consumes out_data this cycle
//   count      number of stored words, 0..Depth
module stream_fifo_32b #(
    parameter int unsigned Size  = 32,
    parameter int unsigned Depth = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [Size-1:0]            in_data,
    input  logic                       in_valid,
    output logic                       in_ready,
    output logic [Size-1:0]            out_data,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [$clog2(Depth):0]     count
);

    localparam int unsigned PtrW = $clog2(Depth);
    localparam int unsigned CntW = PtrW + 1;

    logic [Size-1:0] mem_q [Depth];
    logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0] count_q,  count_d;

    logic empty;
    logic full;
    logic push;
    logic pop;

    // The occupancy counter is the only source of full/empty; the pointers
    // alone cannot tell full from empty when they are equal.
    assign empty = (count_q == '0);
    assign full  = (count_q == CntW'(Depth));

    // Holding in_ready low during reset keeps a word offered in the reset
    // cycle from being written into the array.
    assign in_ready  = !full && !rst;
    assign out_valid = !empty;
    assign out_data  = out_valid ? mem_q[rd_ptr_q] : '0;
    assign count     = count_q;

    assign push = in_valid && in_ready;
    assign pop  = out_valid && out_ready;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;

        // Depth is a power of two, so plain increment wraps modulo Depth.
        if (push) begin
            wr_ptr_d = wr_ptr_q + PtrW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PtrW'(1);
        end

        case ({push, pop})
            2'b10:   count_d = count_q + CntW'(1);
            2'b01:   count_d = count_q - CntW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage is not reset; stale contents are masked by count_q/out_valid.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= in_data;
        end
    end

endmodule

// File: tb/tb_stream_fifo_32b.sv
module tb_stream_fifo_32b;

    localparam int DEPTH = 4;

    logic        clk;
    logic        rst;
    logic [31:0] in_data;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] out_data;
    logic        out_valid;
    logic        out_ready;
    logic [2:0]  count;

    int checks = 0;
    int errors = 0;

    logic [31:0] model_q[$];
    logic [31:0] got_q[$];
    bit          model_live = 0;

    stream_fifo_32b #(
        .Size (32),
        .Depth(DEPTH)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .in_data  (in_data),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .out_data (out_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .count    (count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference queue: updated on the same edge the DUT samples its inputs.
    always @(posedge clk) begin
        bit do_pop;
        bit do_push;
        if (rst) begin
            model_q.delete();
            model_live = 1;
        end else if (model_live) begin
            do_pop  = (model_q.size() > 0) && out_ready;
            do_push = in_valid && (model_q.size() < DEPTH);
            if (do_pop) void'(model_q.pop_front());
            if (do_push) model_q.push_back(in_data);
        end
    end

    // Per-cycle comparison against the queue, plus capture of consumed words.
    always @(negedge clk) begin
        if (model_live) begin
            check("cmp_in_ready", {31'b0, in_ready}, {31'b0, (!rst && model_q.size() < DEPTH)});
            check("cmp_out_valid", {31'b0, out_valid}, {31'b0, (model_q.size() != 0)});
            check("cmp_out_data", out_data, (model_q.size() != 0) ? model_q[0] : 32'h0);
            check("cmp_count", {29'b0, count}, 32'(model_q.size()));
            if (out_valid && out_ready) got_q.push_back(out_data);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Offer a word until the FIFO accepts it (bounded).
    task automatic push_word(input logic [31:0] w);
        bit acc;
        acc = 0;
        in_valid = 1'b1;
        in_data  = w;
        for (int i = 0; i < 20; i++) begin
            #1;
            acc = in_ready;
            step();
            if (acc) break;
        end
        if (!acc) begin
            errors++;
            $display("FAIL push_timeout: word %h never accepted", w);
        end
        in_valid = 1'b0;
    endtask

    task automatic drain();
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 40; i++) begin
            if (!out_valid) break;
            step();
        end
        check("drain_empty", {31'b0, out_valid}, 32'h0);
    endtask

    task automatic check_stream(input string name, input logic [31:0] exp[$]);
        check({name, "_len"}, 32'(got_q.size()), 32'(exp.size()));
        for (int i = 0; i < exp.size(); i++) begin
            check(name, (i < got_q.size()) ? got_q[i] : 32'hxxxxxxxx, exp[i]);
        end
    endtask

    initial begin
        logic [31:0] exp_q[$];

        rst       = 1'b1;
        in_valid  = 1'b1;
        in_data   = 32'hDEADBEEF;
        out_ready = 1'b0;

        // Reset and idle
        step();
        step();
        check("rst_in_ready", {31'b0, in_ready}, 32'h0);
        check("rst_out_valid", {31'b0, out_valid}, 32'h0);
        check("rst_count", {29'b0, count}, 32'h0);
        rst      = 1'b0;
        in_valid = 1'b0;
        #1;
        check("rel_in_ready", {31'b0, in_ready}, 32'h1);
        check("rel_out_valid", {31'b0, out_valid}, 32'h0);
        step();
        check("rel_count", {29'b0, count}, 32'h0);

        // Fill to full
        got_q.delete();
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1;
            in_data  = 32'h11 * (i + 1);
            step();
        end
        in_data = 32'h55;
        #1;
        check("full_count", {29'b0, count}, 32'd4);
        check("full_in_ready", {31'b0, in_ready}, 32'h0);
        check("full_head", out_data, 32'h11);
        step();
        check("full_count_hold", {29'b0, count}, 32'd4);
        check("full_head_hold", out_data, 32'h11);

        // Drain with wrap while pushing 0x55..0x58
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) push_word(32'h55 + i);
        drain();
        exp_q = '{32'h11, 32'h22, 32'h33, 32'h44, 32'h55, 32'h56, 32'h57, 32'h58};
        check_stream("wrap_order", exp_q);

        // Simultaneous push/pop at count=2
        got_q.delete();
        out_ready = 1'b0;
        push_word(32'h100);
        push_word(32'h101);
        check("pp_start_count", {29'b0, count}, 32'd2);
        out_ready = 1'b1;
        in_valid  = 1'b1;
        for (int i = 0; i < 10; i++) begin
            in_data = 32'h102 + i;
            step();
            check("pp_count", {29'b0, count}, 32'd2);
        end
        drain();
        exp_q.delete();
        for (int i = 0; i < 12; i++) exp_q.push_back(32'h100 + i);
        check_stream("pp_order", exp_q);

        // Empty with push: no bypass
        got_q.delete();
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_data   = 32'hCAFE0001;
        #1;
        check("ep_no_bypass", {31'b0, out_valid}, 32'h0);
        check("ep_no_bypass_data", out_data, 32'h0);
        step();
        in_valid = 1'b0;
        #1;
        check("ep_valid", {31'b0, out_valid}, 32'h1);
        check("ep_data", out_data, 32'hCAFE0001);
        step();
        check("ep_count", {29'b0, count}, 32'h0);
        check("ep_empty", {31'b0, out_valid}, 32'h0);

        // Reset mid-stream
        got_q.delete();
        out_ready = 1'b0;
        push_word(32'h1);
        push_word(32'h2);
        push_word(32'h3);
        check("mid_count3", {29'b0, count}, 32'd3);
        rst      = 1'b1;
        in_valid = 1'b1;
        in_data  = 32'h0BAD0BAD;
        out_ready = 1'b1;
        step();
        rst      = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b0;
        #1;
        check("mid_count", {29'b0, count}, 32'h0);
        check("mid_valid", {31'b0, out_valid}, 32'h0);
        check("mid_data", out_data, 32'h0);
        got_q.delete();
        push_word(32'hA5A5A5A5);
        drain();
        exp_q = '{32'hA5A5A5A5};
        check_stream("mid_first", exp_q);

        step();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

endmodule
